// File: rtl/gift_128_pkg.sv
// Shared GIFT-128 primitives: S-box, bit permutation, round constants, key schedule.
package gift_128_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYX,
    ST_READY,
    ST_RUN,
    ST_DONE
  } gift_state_t;

  // GS S-box and its inverse, element 0 first.
  localparam logic [0:15][3:0] GS_SBOX     = 64'h1a4c6f392db7508e;
  localparam logic [0:15][3:0] GS_SBOX_INV = 64'hd0862c4be71a39f5;

  // Round constants from the 6-bit LFSR started at zero (advanced before each round).
  localparam logic [0:39][5:0] RC_ROM = {
    6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3e, 6'h3d, 6'h3b, 6'h37, 6'h2f,
    6'h1e, 6'h3c, 6'h39, 6'h33, 6'h27, 6'h0e, 6'h1d, 6'h3a, 6'h35, 6'h2b,
    6'h16, 6'h2c, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0b, 6'h17, 6'h2e,
    6'h1c, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0d, 6'h1b, 6'h36, 6'h2d, 6'h1a
  };

  // Out-of-range indices only occur on a saturated counter and are never consumed.
  function automatic logic [5:0] rc_lookup(input logic [5:0] idx);
    return (idx < 6'd40) ? RC_ROM[idx] : 6'd0;
  endfunction

  // P128: destination position of state bit i.
  function automatic int p128(input int i);
    return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
  endfunction

  function automatic logic [127:0] perm_bits(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[p128(i)] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] perm_bits_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = s[p128(i)];
    return r;
  endfunction

  function automatic logic [127:0] sub_cells(input logic [127:0] s);
    logic [127:0] r;
    for (int n = 0; n < 32; n++) r[4*n +: 4] = GS_SBOX[s[4*n +: 4]];
    return r;
  endfunction

  function automatic logic [127:0] sub_cells_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int n = 0; n < 32; n++) r[4*n +: 4] = GS_SBOX_INV[s[4*n +: 4]];
    return r;
  endfunction

  // Round-key and constant mask: U = k5||k4 into bits 4i+2, V = k1||k0 into bits 4i+1.
  function automatic logic [127:0] round_mask(input logic [127:0] key, input logic [5:0] rc);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[4*i+2] = key[64+i];
      m[4*i+1] = key[i];
    end
    m[23]  = rc[5];
    m[19]  = rc[4];
    m[15]  = rc[3];
    m[11]  = rc[2];
    m[7]   = rc[1];
    m[3]   = rc[0];
    m[127] = 1'b1;
    return m;
  endfunction

  // k7..k0 <= k1>>>2, k0>>>12, k7..k2 (k7 is the most significant word).
  function automatic logic [127:0] key_update(input logic [127:0] k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction

  function automatic logic [127:0] key_update_inv(input logic [127:0] k);
    return {k[95:0], k[125:112], k[127:126], k[99:96], k[111:100]};
  endfunction

endpackage

// File: rtl/gift_128_round_unit.sv
// One combinational GIFT-128 round, forward or inverse, with its key-schedule step.
module gift_128_round_unit
  import gift_128_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [5:0]   rc,
  input  logic         mode,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  logic [127:0] round_key;

  // Decrypt rewinds the key first so the register always holds the key of the round just done.
  always_comb begin
    round_key  = (mode == MODE_DEC) ? key_update_inv(key) : key;
    next_key   = (mode == MODE_DEC) ? round_key : key_update(key);
    next_state = perm_bits(sub_cells(state)) ^ round_mask(round_key, rc);
    if (mode == MODE_DEC) begin
      next_state = sub_cells_inv(perm_bits_inv(state ^ round_mask(round_key, rc)));
    end
  end

endmodule

// File: rtl/gift_128_codec_core.sv
// GIFT-128 encrypt/decrypt engine: FSM, counters, key registers and handshakes.
module gift_128_codec_core
  import gift_128_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int NUM_ROUNDS       = 40
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_ld,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         out_mode,
  output logic         busy
);

  localparam int         N  = NUM_ROUNDS / ROUNDS_PER_CYCLE;
  localparam logic [5:0] N6 = 6'(N);

  if (NUM_ROUNDS != 40) begin : g_bad_num_rounds
    $error("gift_128_codec_core: NUM_ROUNDS must be 40");
  end
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("gift_128_codec_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 5, 8 or 10");
  end

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v >= N6) ? N6 : v + 6'd1;
  endfunction

  gift_state_t  state_q, state_d;
  logic [5:0]   cnt_q;
  logic [127:0] key_k0_q, key_k40_q, run_key_q, blk_q;
  logic         key_ready_q, mode_q, out_valid_q, out_mode_q;
  logic [127:0] data_out_q;
  logic         key_acc, in_rdy, in_acc, out_acc, last;
  logic         chain_mode;
  logic [5:0]   round_base;
  logic [127:0] chain_state [0:ROUNDS_PER_CYCLE];
  logic [127:0] chain_key   [0:ROUNDS_PER_CYCLE];

  assign key_acc = key_ld & (state_q == ST_IDLE || state_q == ST_READY);
  assign in_rdy  = key_ready_q & ~key_ld &
                   (state_q == ST_READY || (state_q == ST_DONE && out_ready));
  assign in_acc  = in_valid & in_rdy;
  assign out_acc = out_valid_q & out_ready;
  assign last    = (cnt_q == N6 - 6'd1);

  assign key_ready = key_ready_q;
  assign in_ready  = in_rdy;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_mode  = out_mode_q;
  assign busy      = (state_q == ST_KEYX) || (state_q == ST_RUN);

  // The round chain doubles as the key expander while in KEYX (forward key schedule only).
  assign chain_mode     = (state_q == ST_KEYX) ? MODE_ENC : mode_q;
  assign chain_state[0] = blk_q;
  assign chain_key[0]   = (state_q == ST_KEYX) ? key_k40_q : run_key_q;
  assign round_base     = cnt_q * 6'(ROUNDS_PER_CYCLE);

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [5:0] round_idx;
    assign round_idx = (chain_mode == MODE_DEC) ? 6'(NUM_ROUNDS - 1 - j) - round_base
                                                : round_base + 6'(j);
    gift_128_round_unit u_round (
      .state      (chain_state[j]),
      .key        (chain_key[j]),
      .rc         (rc_lookup(round_idx)),
      .mode       (chain_mode),
      .next_state (chain_state[j+1]),
      .next_key   (chain_key[j+1])
    );
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (key_acc) state_d = ST_KEYX;
      ST_KEYX:  if (last) state_d = ST_READY;
      ST_READY: begin
        if (key_acc)     state_d = ST_KEYX;
        else if (in_acc) state_d = ST_RUN;
      end
      ST_RUN:   if (last) state_d = ST_DONE;
      ST_DONE:  if (out_acc) state_d = in_acc ? ST_RUN : ST_READY;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control, key registers and output register; all cleared by reset.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_k0_q    <= '0;
      key_k40_q   <= '0;
      key_ready_q <= 1'b0;
      mode_q      <= MODE_ENC;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q <= state_d;
      if (key_acc || in_acc) cnt_q <= '0;
      else if (state_q == ST_KEYX || state_q == ST_RUN) cnt_q <= sat_inc(cnt_q);
      if (key_acc) begin
        key_k0_q    <= key_in;
        key_k40_q   <= key_in;
        key_ready_q <= 1'b0;
      end else if (state_q == ST_KEYX) begin
        key_k40_q <= chain_key[ROUNDS_PER_CYCLE];
        if (last) key_ready_q <= 1'b1;
      end
      if (in_acc) mode_q <= in_mode;
      if (state_q == ST_RUN && last) begin
        out_valid_q <= 1'b1;
        data_out_q  <= chain_state[ROUNDS_PER_CYCLE];
        out_mode_q  <= mode_q;
      end else if (out_acc) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Working block and round key; pure data, no reset needed.
  always_ff @(posedge clk_i) begin
    if (in_acc) begin
      blk_q     <= data_in;
      run_key_q <= (in_mode == MODE_DEC) ? key_k40_q : key_k0_q;
    end else if (state_q == ST_RUN) begin
      blk_q     <= chain_state[ROUNDS_PER_CYCLE];
      run_key_q <= chain_key[ROUNDS_PER_CYCLE];
    end
  end

endmodule
